// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the iterative signed multiply/divide controller.
package mult_div_ctrl_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_ITERS = 32;
   localparam logic [4:0] MD_LAST = 5'(MD_ITERS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN_MULT = 3'd1,
      RUN_DIV  = 3'd2,
      DONE     = 3'd3,
      DZERO    = 3'd4
   } md_state_e;

   // Two's complement magnitude; 0x80000000 maps to 2^31 as an unsigned value.
   function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v);
      return v[MD_WIDTH-1] ? ('0 - v) : v;
   endfunction

endpackage

// File: rtl/mult_div_ctrl_step.sv
// One radix-2 step: shift-add multiply (op_i=0) or restoring divide (op_i=1)
// on the {hi,lo} accumulator pair using unsigned magnitudes.
import mult_div_ctrl_pkg::*;

module md_iter_step (
   input  logic                op_i,
   input  logic [MD_WIDTH-1:0] hi_i,
   input  logic [MD_WIDTH-1:0] lo_i,
   input  logic [MD_WIDTH-1:0] opnd_i,
   output logic [MD_WIDTH-1:0] hi_o,
   output logic [MD_WIDTH-1:0] lo_o
);

   logic [MD_WIDTH:0] sum;
   logic [MD_WIDTH:0] rem_sh;
   logic [MD_WIDTH:0] diff;

   always_comb begin
      sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
      rem_sh = {hi_i, lo_i[MD_WIDTH-1]};
      // Remainder stays below the divisor magnitude, so bit MD_WIDTH flags a borrow.
      diff   = rem_sh - {1'b0, opnd_i};
      if (!op_i) begin
         hi_o = sum[MD_WIDTH:1];
         lo_o = {sum[0], lo_i[MD_WIDTH-1:1]};
      end else if (!diff[MD_WIDTH]) begin
         hi_o = diff[MD_WIDTH-1:0];
         lo_o = {lo_i[MD_WIDTH-2:0], 1'b1};
      end else begin
         hi_o = rem_sh[MD_WIDTH-1:0];
         lo_o = {lo_i[MD_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mult_div_ctrl.sv
// Signed 32x32 multiply / 32/32 divide controller, one iteration per cycle,
// with HI/LO result registers and a divide-by-zero pulse.
import mult_div_ctrl_pkg::*;

module mult_div_ctrl (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_mult,
   input  logic                start_div,
   input  logic [MD_WIDTH-1:0] op_a,
   input  logic [MD_WIDTH-1:0] op_b,
   output logic                busy,
   output logic                done,
   output logic                hi_lo_write,
   output logic                div_zero,
   output logic [MD_WIDTH-1:0] hi,
   output logic [MD_WIDTH-1:0] lo
);

   md_state_e             state_q;
   logic [4:0]            cnt_q;
   logic [MD_WIDTH-1:0]   acc_hi_q, acc_lo_q, opnd_q;
   logic                  neg_q_q, neg_r_q;
   logic [MD_WIDTH-1:0]   hi_q, lo_q;
   logic                  busy_q, done_q, dz_q;

   logic [MD_WIDTH-1:0]   step_hi, step_lo;
   logic [MD_WIDTH-1:0]   fin_hi_d, fin_lo_d;
   logic [2*MD_WIDTH-1:0] prod_d;

   md_iter_step u_step (
      .op_i   (state_q == RUN_DIV),
      .hi_i   (acc_hi_q),
      .lo_i   (acc_lo_q),
      .opnd_i (opnd_q),
      .hi_o   (step_hi),
      .lo_o   (step_lo)
   );

   // Sign correction is applied to the output of the final step so the
   // corrected result lands in hi/lo on the same edge as iteration 31.
   always_comb begin
      prod_d   = {step_hi, step_lo};
      fin_hi_d = step_hi;
      fin_lo_d = step_lo;
      if (state_q == RUN_DIV) begin
         fin_lo_d = neg_q_q ? ('0 - step_lo) : step_lo;
         fin_hi_d = neg_r_q ? ('0 - step_hi) : step_hi;
      end else begin
         if (neg_q_q) prod_d = '0 - prod_d;
         fin_hi_d = prod_d[2*MD_WIDTH-1:MD_WIDTH];
         fin_lo_d = prod_d[MD_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_mult) begin
                  state_q  <= RUN_MULT;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  acc_hi_q <= '0;
                  acc_lo_q <= md_abs(op_b);
                  opnd_q   <= md_abs(op_a);
                  neg_q_q  <= op_a[MD_WIDTH-1] ^ op_b[MD_WIDTH-1];
                  neg_r_q  <= 1'b0;
               end else if (start_div) begin
                  if (op_b == '0) begin
                     state_q <= DZERO;
                     dz_q    <= 1'b1;
                  end else begin
                     state_q  <= RUN_DIV;
                     busy_q   <= 1'b1;
                     cnt_q    <= '0;
                     acc_hi_q <= '0;
                     acc_lo_q <= md_abs(op_a);
                     opnd_q   <= md_abs(op_b);
                     neg_q_q  <= op_a[MD_WIDTH-1] ^ op_b[MD_WIDTH-1];
                     neg_r_q  <= op_a[MD_WIDTH-1];
                  end
               end
            end
            RUN_MULT, RUN_DIV: begin
               acc_hi_q <= step_hi;
               acc_lo_q <= step_lo;
               cnt_q    <= cnt_q + 5'd1;
               if (cnt_q == MD_LAST) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  hi_q    <= fin_hi_d;
                  lo_q    <= fin_lo_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            DZERO: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi_lo_write = done_q;
   assign div_zero    = dz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: latency, results, divide-by-zero, reset abort.
module tb_mult_div_ctrl;

   logic        clk;
   logic        reset;
   logic        start_mult, start_div;
   logic [31:0] op_a, op_b;
   logic        busy, done, hi_lo_write, div_zero;
   logic [31:0] hi, lo;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] prev_hi = '0;
   logic [31:0] prev_lo = '0;

   mult_div_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start_mult  (start_mult),
      .start_div   (start_div),
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .done        (done),
      .hi_lo_write (hi_lo_write),
      .div_zero    (div_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // mode: 0 mult, 1 div, 2 both starts; mid pulses start_div (op_b=0) mid-run
   task automatic run_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input bit mid);
      int k;
      bit seen_dz;
      @(negedge clk);
      op_a       = a;
      op_b       = b;
      start_mult = (mode != 1);
      start_div  = (mode != 0);
      @(posedge clk); #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      chk("busy_at_E", busy, 1);
      chk("done_at_E", done, 0);
      k       = 0;
      seen_dz = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (mid && i == 6) start_div = 1'b0;
         if (div_zero) seen_dz = 1'b1;
         if (done) begin
            k = i;
            break;
         end
         if (mid && i == 5) begin
            start_div = 1'b1;
            op_b      = '0;
         end
         if (i == 10) begin
            chk("hold_hi", hi, prev_hi);
            chk("hold_lo", lo, prev_lo);
            chk("busy_run", busy, 1);
         end
      end
      chk("latency", k, 32);
      chk("hi", hi, ehi);
      chk("lo", lo, elo);
      chk("hi_lo_write", hi_lo_write, 1);
      chk("no_dz_in_run", seen_dz, 0);
      @(posedge clk); #1;
      chk("done_off", done, 0);
      chk("busy_off", busy, 0);
      prev_hi = ehi;
      prev_lo = elo;
   endtask

   initial begin
      bit seen_done;
      reset      = 1'b0;
      start_mult = 1'b0;
      start_div  = 1'b0;
      op_a       = '0;
      op_b       = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hlw", hi_lo_write, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_hilo", {hi, lo}, 64'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_op(0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
      run_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0);
      run_op(0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
      run_op(1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
      run_op(1, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 0);

      // divide by zero: one-cycle pulse, no done, hi/lo untouched
      @(negedge clk);
      op_a      = 32'd5;
      op_b      = 32'd0;
      start_div = 1'b1;
      @(posedge clk); #1;
      start_div = 1'b0;
      chk("dz_pulse", div_zero, 1);
      chk("dz_done", done, 0);
      chk("dz_busy", busy, 0);
      chk("dz_hilo", {hi, lo}, {prev_hi, prev_lo});
      @(posedge clk); #1;
      chk("dz_off", div_zero, 0);
      chk("dz_done2", done, 0);

      run_op(2, 32'd3, 32'd2, 32'h0, 32'h6, 1);

      // reset at E+10 of a multiply
      @(negedge clk);
      op_a       = 32'h0001_2345;
      op_b       = 32'h0000_0010;
      start_mult = 1'b1;
      @(posedge clk); #1;
      start_mult = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_hilo", {hi, lo}, 64'h0);
      repeat (2) @(negedge clk);
      reset     = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen_done = 1'b1;
      end
      chk("abort_no_done", seen_done, 0);
      prev_hi = '0;
      prev_lo = '0;

      run_op(0, 32'd2, 32'd2, 32'h0, 32'h4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
